// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Round-robin arbiter that funnels NREQ register-file write requesters onto a
// single registered write port (wr_en / wr_addr / wr_data) with a fixed
// one-cycle latency from the accepting handshake to the write.
//
// Optional build macro: RF_ARB_ZERO_REG_DROP_EN
//   When defined, a request to the top register (addr = 2**ADDR_W-1) is still
//   accepted normally (ready, pointer advance) but its write is suppressed.
//   When undefined, that address behaves like any other.

module rf_write_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic [$clog2(NREQ)-1:0]  rr_ptr
);

  localparam int PTR_W = $clog2(NREQ);
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NREQ - 1);

  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];

  logic              found;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  ptr_next;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              drop;
  int                idx;

  // Unpack the flat request buses into per-requester views.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Search upward from rr_ptr (wrapping) for the first valid requester.
  // Reset and flush both blank the grant so nothing transfers in those cycles.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[PTR_W'(idx)]) begin
        found     = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
    if (reset || flush) found = 1'b0;
  end

  // Expand the winning index into a one-hot-or-zero ready vector.
  always_comb begin
    req_ready = '0;
    if (found) req_ready[grant_idx] = 1'b1;
  end

  assign ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
  assign sel_addr = addr_arr[grant_idx];
  assign sel_data = data_arr[grant_idx];

`ifdef RF_ARB_ZERO_REG_DROP_EN
  // Writes to the top register are swallowed: accepted but never issued.
  assign drop = (sel_addr == TOP_ADDR);
`else
  assign drop = 1'b0;
`endif

  // Write-port register and round-robin pointer update.
  // A dropped write is treated like an idle cycle on the write port, so the
  // last issued address/data stay visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rr_ptr  <= '0;
    end else if (flush) begin
      wr_en  <= 1'b0;
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= ptr_next;
      wr_en  <= !drop;
      if (!drop) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end else begin
      wr_en <= 1'b0;
    end
  end

  // The grant vector must never name more than one requester.
  always_ff @(posedge clk) begin
    if (!reset) assert ($onehot0(req_ready));
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: a directed vector table, a few
// hand-written corner sequences, then random traffic against a reference model.

module tb_rf_write_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

`ifdef RF_ARB_ZERO_REG_DROP_EN
  localparam bit DROP_TOP = 1'b1;
`else
  localparam bit DROP_TOP = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    flush;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*ADDR_W-1:0]  req_addr;
  logic [NREQ*DATA_W-1:0]  req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [1:0]              rr_ptr;

  logic [ADDR_W-1:0] a_in [NREQ];
  logic [DATA_W-1:0] d_in [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign req_addr[i*ADDR_W +: ADDR_W] = a_in[i];
    assign req_data[i*DATA_W +: DATA_W] = d_in[i];
  end

  rf_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  int                m_ptr;
  bit                m_wr_en;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [NREQ-1:0]   dut_ready_s;
  int                waitc [NREQ];

  typedef struct {
    logic [NREQ-1:0]   valid;
    logic              flush;
    logic [NREQ-1:0]   exp_ready;
    int                exp_ptr;
    logic              exp_wr_en;
    logic [ADDR_W-1:0] exp_addr;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
  endtask

  // Round-robin rule: first valid requester at or after the pointer, wrapping.
  function automatic int model_pick();
    if (reset || flush) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int j = (m_ptr + k) % NREQ;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic check_now();
    int g = model_pick();
    logic [NREQ-1:0] er = '0;
    if (g >= 0) er[g] = 1'b1;
    dut_ready_s = req_ready;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("rr_ptr",    64'(rr_ptr),    64'(m_ptr));
    chk("wr_en",     64'(wr_en),     64'(m_wr_en));
    chk("wr_addr",   64'(wr_addr),   64'(m_addr));
    chk("wr_data",   64'(wr_data),   64'(m_data));
  endtask

  task automatic advance();
    int g;
    @(posedge clk);
    g = model_pick();
    // starvation bound judged from the DUT's own grants
    for (int i = 0; i < NREQ; i++) begin
      if (reset || flush) waitc[i] = 0;
      else if (req_valid[i] && dut_ready_s[i]) begin
        chk("starve_bound", 64'(waitc[i] <= NREQ - 1), 64'd1);
        waitc[i] = 0;
      end else if (req_valid[i]) waitc[i]++;
      else waitc[i] = 0;
    end
    if (reset) begin
      m_ptr = 0; m_wr_en = 0; m_addr = '0; m_data = '0;
    end else if (flush) begin
      m_ptr = 0; m_wr_en = 0;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % NREQ;
      if (DROP_TOP && a_in[g] == {ADDR_W{1'b1}}) m_wr_en = 0;
      else begin
        m_wr_en = 1; m_addr = a_in[g]; m_data = d_in[g];
      end
    end else begin
      m_wr_en = 0;
    end
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    check_now();
    advance();
  endtask

  task automatic set_default_reqs();
    for (int i = 0; i < NREQ; i++) begin
      a_in[i] = ADDR_W'(i + 1);
      d_in[i] = 64'h100 + 64'(i);
    end
  endtask

  initial begin
    //            valid    flush  ready    ptr wr_en addr
    vecs[0]  = '{4'b0000, 1'b0, 4'b0000, 0, 1'b0, 5'd0};
    vecs[1]  = '{4'b1111, 1'b0, 4'b0001, 0, 1'b0, 5'd0};
    vecs[2]  = '{4'b1111, 1'b0, 4'b0010, 1, 1'b1, 5'd1};
    vecs[3]  = '{4'b1111, 1'b0, 4'b0100, 2, 1'b1, 5'd2};
    vecs[4]  = '{4'b1111, 1'b0, 4'b1000, 3, 1'b1, 5'd3};
    vecs[5]  = '{4'b0000, 1'b0, 4'b0000, 0, 1'b1, 5'd4};
    vecs[6]  = '{4'b0100, 1'b0, 4'b0100, 0, 1'b0, 5'd4};
    vecs[7]  = '{4'b0011, 1'b0, 4'b0001, 3, 1'b1, 5'd3};
    vecs[8]  = '{4'b0000, 1'b0, 4'b0000, 1, 1'b1, 5'd1};
    vecs[9]  = '{4'b0010, 1'b0, 4'b0010, 1, 1'b0, 5'd1};
    vecs[10] = '{4'b0011, 1'b0, 4'b0001, 2, 1'b1, 5'd2};
    vecs[11] = '{4'b0000, 1'b0, 4'b0000, 1, 1'b1, 5'd1};
    vecs[12] = '{4'b0100, 1'b0, 4'b0100, 1, 1'b0, 5'd1};
    vecs[13] = '{4'b0100, 1'b1, 4'b0000, 3, 1'b1, 5'd3};
    vecs[14] = '{4'b0000, 1'b0, 4'b0000, 0, 1'b0, 5'd3};

    for (int i = 0; i < NREQ; i++) waitc[i] = 0;
    dut_ready_s = '0;
    reset = 1'b1; flush = 1'b0; req_valid = '0;
    set_default_reqs();
    @(posedge clk); #1;
    m_ptr = 0; m_wr_en = 0; m_addr = '0; m_data = '0;
    step();
    reset = 1'b0;

    // directed table
    for (int v = 0; v < 15; v++) begin
      req_valid = vecs[v].valid;
      flush     = vecs[v].flush;
      @(negedge clk);
      check_now();
      chk($sformatf("vec%0d_ready", v), 64'(req_ready), 64'(vecs[v].exp_ready));
      chk($sformatf("vec%0d_ptr", v),   64'(rr_ptr),    64'(vecs[v].exp_ptr));
      chk($sformatf("vec%0d_wr_en", v), 64'(wr_en),     64'(vecs[v].exp_wr_en));
      chk($sformatf("vec%0d_addr", v),  64'(wr_addr),   64'(vecs[v].exp_addr));
      advance();
    end
    flush = 1'b0;

    // top-register write from requester 1
    reset = 1'b1; req_valid = '0; step(); reset = 1'b0;
    req_valid = 4'b0010; a_in[1] = 5'd31; d_in[1] = 64'hDEAD;
    @(negedge clk); check_now();
    chk("x31_ready", 64'(req_ready), 64'b0010);
    advance();
    req_valid = '0;
    @(negedge clk); check_now();
    chk("x31_wr_en", 64'(wr_en), DROP_TOP ? 64'd0 : 64'd1);
    chk("x31_ptr",   64'(rr_ptr), 64'd2);
    advance();
    set_default_reqs();

    // reset arriving in the cycle a grant would occur
    req_valid = 4'b0001; a_in[0] = 5'd5;
    step();
    req_valid = 4'b1111; reset = 1'b1;
    @(negedge clk); check_now();
    chk("rst_ready", 64'(req_ready), 64'd0);
    advance();
    reset = 1'b0; req_valid = '0;
    @(negedge clk); check_now();
    chk("rst_wr_en", 64'(wr_en),   64'd0);
    chk("rst_addr",  64'(wr_addr), 64'd0);
    chk("rst_ptr",   64'(rr_ptr),  64'd0);
    advance();

    // random traffic; a requester keeps its request until it transfers
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && !dut_ready_s[i])) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          a_in[i] = ADDR_W'($urandom_range(0, 31));
          d_in[i] = {$urandom, $urandom};
        end
      end
      flush = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 59) == 0);
      step();
    end
    reset = 1'b0; flush = 1'b0; req_valid = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
